// File: rtl/bullet_writer.sv
// Write-side sequencer for the 64-entry bullet RAM: clears it after reset, then
// once per frame ages, moves, retires and spawns bullets with one read-modify-write per slot.
`timescale 1ns/1ps
module bullet_writer #(
  parameter int MAX_BULLETS  = 64,
  parameter int SPRITE_SIZE  = 64,
  parameter int BULLET_SIZE  = 8,
  parameter int BULLET_SPEED = 4,
  parameter int TTL_INIT     = 20,
  parameter int X_MAX        = 504,
  parameter int Y_MAX        = 472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        shoot,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [2:0]  tank_dir,
  output logic [5:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic [6:0]  bullet_count,
  output logic        spawn_drop
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_MODIFY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [5:0]         LAST_SLOT = 6'(MAX_BULLETS - 1);
  localparam logic signed [10:0] STEP      = 11'(BULLET_SPEED);
  localparam logic signed [10:0] X_LIM     = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM     = 11'(Y_MAX);
  localparam logic [10:0]        SPAWN_OFS = 11'(SPRITE_SIZE / 2 - BULLET_SIZE / 2);
  localparam logic [10:0]        X_CLAMP   = 11'(X_MAX);
  localparam logic [10:0]        Y_CLAMP   = 11'(Y_MAX);

  logic [2:0]  state, state_next;
  logic [5:0]  index;
  logic [6:0]  active_cnt;
  logic [31:5] word;
  logic        spawn_pending;
  logic [2:0]  frame_sync, shoot_sync;
  logic        frame_pulse, shoot_pulse;

  // Reserved low bits of the stored word carry no information.
  logic unused_rsvd;
  assign unused_rsvd = ^rd_data[4:0];

  // Bits [1:0] are the synchroniser, bit [2] remembers the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_sync <= 3'b000;
      shoot_sync <= 3'b000;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_tick};
      shoot_sync <= {shoot_sync[1:0], shoot};
    end
  end

  assign frame_pulse = frame_sync[1] & ~frame_sync[2];
  assign shoot_pulse = shoot_sync[1] & ~shoot_sync[2];

  logic [8:0]         wx, wy;
  logic [4:0]         wttl;
  logic [2:0]         wdir;
  logic               wact;
  logic signed [10:0] dx_step, dy_step, nx, ny;
  logic [10:0]        sx_raw, sy_raw;
  logic [8:0]         sx, sy;

  assign {wx, wy, wttl, wdir, wact} = word;

  always_comb begin
    dx_step = 11'sd0;
    dy_step = 11'sd0;
    case (wdir)
      3'd0:    begin dx_step = 11'sd0; dy_step = -STEP;  end
      3'd1:    begin dx_step = STEP;   dy_step = -STEP;  end
      3'd2:    begin dx_step = STEP;   dy_step = 11'sd0; end
      3'd3:    begin dx_step = STEP;   dy_step = STEP;   end
      3'd4:    begin dx_step = 11'sd0; dy_step = STEP;   end
      3'd5:    begin dx_step = -STEP;  dy_step = STEP;   end
      3'd6:    begin dx_step = -STEP;  dy_step = 11'sd0; end
      3'd7:    begin dx_step = -STEP;  dy_step = -STEP;  end
      default: begin dx_step = 11'sd0; dy_step = 11'sd0; end
    endcase
  end

  assign nx     = $signed({2'b00, wx}) + dx_step;
  assign ny     = $signed({2'b00, wy}) + dy_step;
  assign sx_raw = {1'b0, tank_x} + SPAWN_OFS;
  assign sy_raw = {1'b0, tank_y} + SPAWN_OFS;
  assign sx     = (sx_raw > X_CLAMP) ? 9'(X_MAX) : sx_raw[8:0];
  assign sy     = (sy_raw > Y_CLAMP) ? 9'(Y_MAX) : sy_raw[8:0];

  logic [31:0] mod_word;
  logic        mod_live, mod_spawn;

  // New contents for the slot currently held in word.
  always_comb begin
    mod_word  = 32'd0;
    mod_live  = 1'b0;
    mod_spawn = 1'b0;
    if (wact) begin
      if (wttl <= 5'd1) begin
        mod_word = 32'd0;
      end else if ((nx < 11'sd0) || (nx > X_LIM) || (ny < 11'sd0) || (ny > Y_LIM)) begin
        mod_word = 32'd0;
      end else begin
        mod_word = {nx[8:0], ny[8:0], wttl - 5'd1, wdir, 1'b1, 5'd0};
        mod_live = 1'b1;
      end
    end else if (spawn_pending) begin
      mod_word  = {sx, sy, 5'(TTL_INIT), tank_dir, 1'b1, 5'd0};
      mod_live  = 1'b1;
      mod_spawn = 1'b1;
    end else begin
      mod_word = 32'd0;
    end
  end

  // Sweep sequencing.
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR:  state_next = (index == LAST_SLOT) ? S_IDLE : S_CLEAR;
      S_IDLE:   state_next = frame_pulse ? S_READ : S_IDLE;
      S_READ:   state_next = S_WAIT;
      S_WAIT:   state_next = S_MODIFY;
      S_MODIFY: state_next = (index == LAST_SLOT) ? S_DONE : S_READ;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_CLEAR;
    endcase
  end

  // Datapath and registered outputs; a shot landing in DONE survives to the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_CLEAR;
      index         <= 6'd0;
      active_cnt    <= 7'd0;
      word          <= 27'd0;
      spawn_pending <= 1'b0;
      rd_addr       <= 6'd0;
      wr_en         <= 1'b0;
      wr_addr       <= 6'd0;
      wr_data       <= 32'd0;
      busy          <= 1'b1;
      bullet_count  <= 7'd0;
      spawn_drop    <= 1'b0;
    end else begin
      state         <= state_next;
      busy          <= (state_next != S_IDLE);
      wr_en         <= 1'b0;
      spawn_drop    <= 1'b0;
      spawn_pending <= spawn_pending | shoot_pulse;
      case (state)
        S_CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= index;
          wr_data <= 32'd0;
          index   <= index + 6'd1;
        end
        S_IDLE: begin
          if (frame_pulse) begin
            index      <= 6'd0;
            rd_addr    <= 6'd0;
            active_cnt <= 7'd0;
          end else begin
            index <= index;
          end
        end
        S_READ: begin
          rd_addr <= index;
        end
        S_WAIT: begin
          word <= rd_data[31:5];
        end
        S_MODIFY: begin
          wr_en   <= 1'b1;
          wr_addr <= index;
          wr_data <= mod_word;
          index   <= index + 6'd1;
          rd_addr <= index + 6'd1;
          if (mod_live) begin
            active_cnt <= active_cnt + 7'd1;
          end else begin
            active_cnt <= active_cnt;
          end
          if (mod_spawn) begin
            spawn_pending <= 1'b0;
          end else begin
            spawn_pending <= spawn_pending | shoot_pulse;
          end
        end
        S_DONE: begin
          bullet_count <= active_cnt;
          if (spawn_pending) begin
            spawn_drop    <= 1'b1;
            spawn_pending <= shoot_pulse;
          end else begin
            spawn_drop <= 1'b0;
          end
        end
        default: begin
          index <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_writer.sv
// Bench for bullet_writer: a synchronous RAM model plus a per-bullet reference
// model of the frame rules, driven by directed and randomized frames.
`timescale 1ns/1ps
module tb_bullet_writer;

  logic        clk = 1'b0;
  logic        reset, frame_tick, shoot;
  logic [9:0]  tank_x, tank_y;
  logic [2:0]  tank_dir;
  logic [5:0]  rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        wr_en, busy, spawn_drop;
  logic [6:0]  bullet_count;

  bullet_writer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .shoot(shoot),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .bullet_count(bullet_count), .spawn_drop(spawn_drop)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = 6'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk) begin
    rd_data <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
    else if (pl_en) ram[pl_addr] <= pl_data;
  end

  int drop_cnt = 0;
  always @(negedge clk) if (spawn_drop === 1'b1) drop_cnt++;

  typedef struct { int x; int y; int ttl; int dir; bit act; } blt_t;
  blt_t mdl [64];
  bit   mdl_pend = 1'b0;
  int   mdl_count = 0;
  int   mdl_drops = 0;
  int   dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int   dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input blt_t b);
    logic [8:0] px, py;
    logic [4:0] pt;
    logic [2:0] pd;
    if (!b.act) return 32'd0;
    px = b.x[8:0]; py = b.y[8:0]; pt = b.ttl[4:0]; pd = b.dir[2:0];
    return {px, py, pt, pd, 1'b1, 5'd0};
  endfunction

  function automatic blt_t mk(input int x, input int y, input int ttl, input int dir);
    blt_t b;
    b.x = x; b.y = y; b.ttl = ttl; b.dir = dir; b.act = 1'b1;
    return b;
  endfunction

  task automatic model_zero();
    blt_t z;
    z = '{0, 0, 0, 0, 1'b0};
    for (int i = 0; i < 64; i++) mdl[i] = z;
  endtask

  // One frame of the rules, applied to the reference bullets with plain integers.
  task automatic model_frame();
    int nx, ny, sx, sy;
    mdl_count = 0;
    for (int i = 0; i < 64; i++) begin
      if (mdl[i].act) begin
        nx = mdl[i].x + dxt[mdl[i].dir] * 4;
        ny = mdl[i].y + dyt[mdl[i].dir] * 4;
        if (mdl[i].ttl <= 1 || nx < 0 || nx > 504 || ny < 0 || ny > 472) begin
          mdl[i].act = 1'b0;
        end else begin
          mdl[i].x = nx; mdl[i].y = ny; mdl[i].ttl--; mdl_count++;
        end
      end else if (mdl_pend) begin
        sx = int'(tank_x) + 28; if (sx > 504) sx = 504;
        sy = int'(tank_y) + 28; if (sy > 472) sy = 472;
        mdl[i] = mk(sx, sy, 20, int'(tank_dir));
        mdl_pend = 1'b0;
        mdl_count++;
      end
    end
    if (mdl_pend) begin
      mdl_drops++;
      mdl_pend = 1'b0;
    end
  endtask

  task automatic compare_ram(input string tag);
    for (int i = 0; i < 64; i++) check($sformatf("%s slot%0d", tag, i), ram[i], pack(mdl[i]));
    check({tag, " bullet_count"}, {25'd0, bullet_count}, 32'(mdl_count));
    check({tag, " spawn_drop pulses"}, 32'(drop_cnt), 32'(mdl_drops));
  endtask

  task automatic load_all();
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_addr = 6'(i); pl_data = pack(mdl[i]);
      @(negedge clk);
    end
    pl_en = 1'b0;
  endtask

  task automatic do_shoot();
    shoot = 1'b1;
    repeat (4) @(negedge clk);
    shoot = 1'b0;
    repeat (4) @(negedge clk);
    mdl_pend = 1'b1;
  endtask

  task automatic run_frame(input string tag);
    int n;
    frame_tick = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, " sweep start"}, {31'd0, busy}, 32'd1);
    frame_tick = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check({tag, " sweep end"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    model_frame();
    compare_ram(tag);
  endtask

  // Follows the CLEAR pass that starts when reset is released.
  task automatic check_clear(input string tag);
    int n, nwr, bad;
    logic [5:0]  exp_addr;
    logic [31:0] acc;
    n = 0; nwr = 0; bad = 0; exp_addr = 6'd0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk); n++;
      if (wr_en === 1'b1) begin
        if (wr_addr !== exp_addr || wr_data !== 32'd0) bad++;
        exp_addr++; nwr++;
      end
    end
    repeat (3) begin @(negedge clk); if (wr_en === 1'b1) nwr++; end
    check({tag, " clear writes"}, 32'(nwr), 32'd64);
    check({tag, " clear addr/data errors"}, 32'(bad), 32'd0);
    check({tag, " busy after clear"}, {31'd0, busy}, 32'd0);
    check({tag, " bullet_count after clear"}, {25'd0, bullet_count}, 32'd0);
    acc = 32'd0;
    for (int i = 0; i < 64; i++) acc = acc | ram[i];
    check({tag, " ram zero after clear"}, acc, 32'd0);
    model_zero();
  endtask

  initial begin
    logic [31:0] w, exp_w;
    int n;
    reset = 1'b1; frame_tick = 1'b0; shoot = 1'b0;
    tank_x = 10'd0; tank_y = 10'd0; tank_dir = 3'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_addr = 6'(i); pl_data = $urandom;
      @(negedge clk);
    end
    pl_en = 1'b0;
    #1;
    check("reset wr_en", {31'd0, wr_en}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd1);
    check("reset rd_addr", {26'd0, rd_addr}, 32'd0);
    check("reset wr_addr", {26'd0, wr_addr}, 32'd0);
    check("reset wr_data", wr_data, 32'd0);
    check("reset bullet_count", {25'd0, bullet_count}, 32'd0);
    check("reset spawn_drop", {31'd0, spawn_drop}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_clear("power-on");

    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 3'd2;
    do_shoot();
    run_frame("spawn");
    w = ram[0];
    exp_w = {9'd128, 9'd228, 5'd20, 3'd2, 1'b1, 5'd0};
    check("spawn slot0 word", w, exp_w);
    run_frame("move");
    w = ram[0];
    check("move slot0 x", {23'd0, w[31:23]}, 32'd132);
    check("move slot0 ttl", {27'd0, w[13:9]}, 32'd19);

    model_zero();
    mdl[0] = mk(502, 100, 10, 2);
    load_all();
    run_frame("edge-exit");
    check("edge-exit slot0", ram[0], 32'd0);
    check("edge-exit count", {25'd0, bullet_count}, 32'd0);

    model_zero();
    load_all();
    tank_x = 10'd300; tank_y = 10'd0; tank_dir = 3'd4;
    do_shoot();
    run_frame("ttl spawn");
    for (int f = 1; f <= 20; f++) begin
      run_frame($sformatf("ttl f%0d", f));
      w = ram[0];
      if (f < 20) check($sformatf("ttl value f%0d", f), {27'd0, w[13:9]}, 32'(20 - f));
      else check("ttl expired", w, 32'd0);
    end

    for (int r = 0; r < 30; r++) begin
      tank_x = 10'($urandom_range(0, 1023));
      tank_y = 10'($urandom_range(0, 1023));
      tank_dir = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_shoot();
      run_frame($sformatf("rand%0d", r));
    end

    for (int i = 0; i < 64; i++) mdl[i] = mk(200, 200, 30, int'($urandom_range(0, 7)));
    load_all();
    n = drop_cnt;
    do_shoot();
    run_frame("full");
    check("full drop once", 32'(drop_cnt - n), 32'd1);
    check("full count", {25'd0, bullet_count}, 32'd64);
    run_frame("full after drop");

    frame_tick = 1'b1;
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === 6'd17) && n < 400) begin @(negedge clk); n++; end
    check("reached slot 17", {26'd0, wr_addr}, 32'd17);
    reset = 1'b1;
    #1;
    check("mid reset wr_en", {31'd0, wr_en}, 32'd0);
    check("mid reset busy", {31'd0, busy}, 32'd1);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_clear("mid-sweep reset");
    mdl_pend = 1'b0;
    tank_x = 10'd40; tank_y = 10'd60; tank_dir = 3'd7;
    do_shoot();
    run_frame("after reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bullet_writer.md
Name: bullet_writer

Overview:
- Owns the write side of the 64-entry bullet RAM that the VGA renderer reads each frame.
- Once per frame it sweeps every slot: ages and moves active bullets, retires expired or off-screen ones, and spawns at most one new bullet from the tank position when shoot is pressed.
- Sits between the button/joystick inputs and the BulletRAM; uses its own read port and the RAM write port.

Parameters:
- MAX_BULLETS, 64, number of RAM slots; address width 6.
- SPRITE_SIZE, 64, tank sprite edge in pixels.
- BULLET_SIZE, 8, bullet edge in pixels.
- BULLET_SPEED, 4, pixels moved per frame per axis.
- TTL_INIT, 20, frames of life for a new bullet; 5-bit field.
- X_MAX, 504, largest legal bullet x (must be ≤ 511).
- Y_MAX, 472, largest legal bullet y.

Ports:
- clk, in, 1, 100 MHz system clock.
- reset, in, 1, asynchronous, active-high.
- frame_tick, in, 1, screenEnd level from the 25 MHz timing domain; rising edge detected internally.
- shoot, in, 1, fire button level; rising edge detected internally.
- tank_x, in, 10, tank sprite left edge.
- tank_y, in, 10, tank sprite top edge.
- tank_dir, in, 3, facing: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
- rd_addr, out, 6, RAM read address, registered.
- rd_data, in, 32, RAM read data, valid the cycle after rd_addr.
- wr_en, out, 1, RAM write strobe.
- wr_addr, out, 6, RAM write address.
- wr_data, out, 32, RAM write word.
- busy, out, 1, high during CLEAR and during a sweep.
- bullet_count, out, 7, active bullets after the last sweep.
- spawn_drop, out, 1, one-cycle pulse when a pending shot found no free slot.

Behaviour:
- Word format:
  - [31:23] x (9 bits)
  - [22:14] y (9 bits)
  - [13:9] ttl
  - [8:6] dir
  - [5] active
  - [4:0] zero
- Inactive slots are written as all-zero.
- Input synchronisation: frame_tick and shoot each pass through a 2-flop synchroniser plus an edge register; a rising edge yields a 1-cycle internal pulse.
- Shoot pulse sets spawn_pending (level); further pulses while pending are absorbed.
- Reset values:
  - State = CLEAR; index = 0.
  - wr_en = 0, rd_addr = 0, wr_addr = 0, wr_data = 0.
  - busy = 1, bullet_count = 0, spawn_drop = 0, spawn_pending = 0.
- FSM states:
  - CLEAR: one cycle per slot, wr_en = 1 with wr_data = 0, addr = index. After slot 63 → IDLE (64 cycles).
  - IDLE: busy = 0. Frame pulse → READ with index = 0 and the active counter zeroed.
  - READ: rd_addr = index → WAIT.
  - WAIT: rd_data captured at end of cycle → MODIFY.
  - MODIFY: wr_en = 1, wr_addr = index, word computed per the rules below. If index = 63 → DONE, else index+1 → READ.
  - DONE: bullet_count = counter; if spawn_pending, pulse spawn_drop and clear it → IDLE.
- Sweep length: 3 cycles per slot, 192 + 1 cycles total.
- MODIFY rules:
  - Active slot with ttl ≤ 1 → write zero.
  - Otherwise compute nx = x + dx·BULLET_SPEED and ny = y + dy·BULLET_SPEED in 11-bit signed arithmetic. dx, dy ∈ {−1, 0, +1} per dir; N is −y, E is +x.
  - If nx < 0, nx > X_MAX, ny < 0 or ny > Y_MAX → write zero.
  - Else write {nx[8:0], ny[8:0], ttl−1, dir, 1, 0}; counter+1.
  - Inactive slot with spawn_pending: write {sx, sy, TTL_INIT, tank_dir, 1, 0}; clear spawn_pending; counter+1. The spawned bullet is not moved this frame.
  - Inactive slot without a pending spawn: write zero.
- Spawn position:
  - sx = tank_x + SPRITE_SIZE/2 − BULLET_SIZE/2, clamped to X_MAX.
  - sy = the same computed from tank_y, clamped to Y_MAX.
  - Tank inputs are sampled in the MODIFY cycle.
- Simultaneous events:
  - A shoot pulse arriving mid-sweep may be served by a later free slot in the same sweep.
  - Frame pulses while busy are ignored.
  - A shoot pulse arriving in the same cycle as DONE stays pending for the next frame.
- Reset mid-sweep aborts immediately and re-enters CLEAR.
- spawn_drop is never asserted outside DONE.

Test Plan:
- Reset release → wr_en high for exactly 64 cycles, addrs 0..63, data 0; busy falls; bullet_count = 0.
- tank_x = 100, tank_y = 200, dir = 2, shoot, one frame → slot 0 = {x = 128, y = 228, ttl = 20, dir = 2, active = 1}; bullet_count = 1. Next frame → x = 132, ttl = 19.
- Bullet at x = 502, dir = E (2), ttl = 10 → one frame writes slot 0; wr_data = 0; bullet_count = 0.
- Spawn with ttl = 20, no moves out of bounds (dir = S from y = 0) → after 20 frames slot is zero. Frames 1..19 show ttl 19..1.
- Preload all 64 active bullets with ttl = 30, shoot, frame → spawn_drop pulses once in DONE; bullet_count = 64.
- Assert reset at index 17 mid-sweep → CLEAR restarts at addr 0; no MODIFY write after reset.
